// File: rtl/load_store_unit_if.sv
// Request, RAM port-B and writeback/exception signals of the load/store unit.
// The unit sits on the slave modport; execute, RAM and writeback sit on master.
interface load_store_unit_if #(
    parameter int cXLEN = 32,
    parameter int cAW   = 10
);
    // Request from execute
    logic             valid;
    logic             ready;
    logic             load;
    logic             store;
    logic [2:0]       funct3;
    logic [cXLEN-1:0] addr;
    logic [cXLEN-1:0] wdata;
    logic [4:0]       rd;
    // RAM port B
    logic             en_b;
    logic             wen_b;
    logic [cAW-1:0]   addr_b;
    logic [cXLEN-1:0] wdata_b;
    logic [cXLEN-1:0] rdata_b;
    // Writeback and exception
    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic [cXLEN-1:0] wb_data;
    logic             exc_valid;
    logic [cXLEN-1:0] exc_addr;

    modport master (
        output valid, load, store, funct3, addr, wdata, rd, rdata_b,
        input  ready, en_b, wen_b, addr_b, wdata_b,
               wb_valid, wb_rd, wb_data, exc_valid, exc_addr
    );

    modport slave (
        input  valid, load, store, funct3, addr, wdata, rd, rdata_b,
        output ready, en_b, wen_b, addr_b, wdata_b,
               wb_valid, wb_rd, wb_data, exc_valid, exc_addr
    );
endinterface

// File: rtl/load_store_unit.sv
// Data-side memory stage: RV32I loads/stores on port B of the shared RAM.
// Sub-word stores are done as read-modify-write because the RAM only has a
// per-word write enable. Faulting requests raise a one-cycle exception pulse.
module load_store_unit #(
    parameter int cXLEN      = 32,
    parameter int cRamDepth  = 1024,
    parameter int cRdLatency = 1      // 1 or 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    load_store_unit_if.slave lsu_io
);
    localparam int cAW = $clog2(cRamDepth);

    localparam logic [2:0] cF3B  = 3'b000;
    localparam logic [2:0] cF3H  = 3'b001;
    localparam logic [2:0] cF3W  = 3'b010;
    localparam logic [2:0] cF3BU = 3'b100;
    localparam logic [2:0] cF3HU = 3'b101;

    typedef enum logic [1:0] {IDLE, RD, WAIT, WR} state_e;

    state_e           state_q;
    logic [1:0]       wait_cnt_q;
    // Latched operation
    logic             is_load_q;
    logic [2:0]       funct3_q;
    logic [1:0]       lane_q;
    logic [cXLEN-1:0] data_q;
    logic [4:0]       rd_q;
    // Registered outputs
    logic             ready_q;
    logic             en_b_q;
    logic             wen_b_q;
    logic [cAW-1:0]   addr_b_q;
    logic [cXLEN-1:0] wdata_b_q;
    logic             wb_valid_q;
    logic [4:0]       wb_rd_q;
    logic [cXLEN-1:0] wb_data_q;
    logic             exc_valid_q;
    logic [cXLEN-1:0] exc_addr_q;

    logic illegal;
    logic misaligned;

    // Extract the addressed byte/half from a read word and extend it.
    function automatic logic [cXLEN-1:0] extract_load(input logic [cXLEN-1:0] word,
                                                      input logic [2:0]       f3,
                                                      input logic [1:0]       lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*lane +: 8];
        h = word[16*lane[1] +: 16];
        case (f3)
            cF3B:    extract_load = {{(cXLEN-8){b[7]}}, b};
            cF3H:    extract_load = {{(cXLEN-16){h[15]}}, h};
            cF3BU:   extract_load = {{(cXLEN-8){1'b0}}, b};
            cF3HU:   extract_load = {{(cXLEN-16){1'b0}}, h};
            default: extract_load = word;
        endcase
    endfunction

    // Overlay the store byte/half onto the word read back from RAM.
    function automatic logic [cXLEN-1:0] merge_store(input logic [cXLEN-1:0] word,
                                                     input logic [cXLEN-1:0] data,
                                                     input logic [2:0]       f3,
                                                     input logic [1:0]       lane);
        logic [cXLEN-1:0] m;
        m = word;
        if (f3 == cF3B) begin
            m[8*lane +: 8] = data[7:0];
        end else begin
            m[16*lane[1] +: 16] = data[15:0];
        end
        return m;
    endfunction

    // Classify the presented request as illegal or misaligned.
    // NOTE: every combinational output is assigned on every path, so no latch is inferred.
    always_comb begin
        illegal    = (lsu_io.load && lsu_io.store)
                   || (lsu_io.funct3 == 3'b011)
                   || (lsu_io.funct3[2:1] == 2'b11)
                   || (lsu_io.store && lsu_io.funct3[2]);
        misaligned = ((lsu_io.funct3[1:0] == 2'b01) && lsu_io.addr[0])
                   || ((lsu_io.funct3[1:0] == 2'b10) && (lsu_io.addr[1:0] != 2'b00));
    end

    // Single FSM: accept, read, wait for RAM data, write; all outputs registered.
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            is_load_q   <= 1'b0;
            funct3_q    <= '0;
            lane_q      <= '0;
            data_q      <= '0;
            rd_q        <= '0;
            ready_q     <= 1'b0;
            en_b_q      <= 1'b0;
            wen_b_q     <= 1'b0;
            addr_b_q    <= '0;
            wdata_b_q   <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            exc_valid_q <= 1'b0;
            exc_addr_q  <= '0;
        end else begin
            wb_valid_q  <= 1'b0;
            exc_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (lsu_io.valid && ready_q && (lsu_io.load || lsu_io.store)) begin
                        if (illegal || misaligned) begin
                            exc_valid_q <= 1'b1;
                            exc_addr_q  <= lsu_io.addr;
                        end else begin
                            ready_q   <= 1'b0;
                            is_load_q <= lsu_io.load;
                            funct3_q  <= lsu_io.funct3;
                            lane_q    <= lsu_io.addr[1:0];
                            data_q    <= lsu_io.wdata;
                            rd_q      <= lsu_io.rd;
                            addr_b_q  <= lsu_io.addr[cAW+1:2];
                            en_b_q    <= 1'b1;
                            if (lsu_io.store && (lsu_io.funct3 == cF3W)) begin
                                wen_b_q   <= 1'b1;
                                wdata_b_q <= lsu_io.wdata;
                                state_q   <= WR;
                            end else begin
                                wen_b_q <= 1'b0;
                                state_q <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    en_b_q     <= 1'b0;
                    wait_cnt_q <= 2'(cRdLatency - 1);
                    state_q    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt_q == 2'd0) begin
                        if (is_load_q) begin
                            wb_valid_q <= (rd_q != 5'd0);
                            wb_rd_q    <= rd_q;
                            wb_data_q  <= extract_load(lsu_io.rdata_b, funct3_q, lane_q);
                            ready_q    <= 1'b1;
                            state_q    <= IDLE;
                        end else begin
                            en_b_q    <= 1'b1;
                            wen_b_q   <= 1'b1;
                            wdata_b_q <= merge_store(lsu_io.rdata_b, data_q, funct3_q, lane_q);
                            state_q   <= WR;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 2'd1;
                    end
                end
                WR: begin
                    en_b_q  <= 1'b0;
                    wen_b_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign lsu_io.ready     = ready_q;
    assign lsu_io.en_b      = en_b_q;
    assign lsu_io.wen_b     = wen_b_q;
    assign lsu_io.addr_b    = addr_b_q;
    assign lsu_io.wdata_b   = wdata_b_q;
    assign lsu_io.wb_valid  = wb_valid_q;
    assign lsu_io.wb_rd     = wb_rd_q;
    assign lsu_io.wb_data   = wb_data_q;
    assign lsu_io.exc_valid = exc_valid_q;
    assign lsu_io.exc_addr  = exc_addr_q;
endmodule
